// File: rtl/mma_datapath_pkg.sv
// Shared definitions for the MMA datapath and control unit: control-line
// bit indices, PSW bit positions, ALU types and a PSW packing helper.
package mma_datapath_pkg;

   // Control-word bit indices (control is declared [0:MAX_CONTROL_LINES-1])
   localparam int INIT_PC           = 0;
   localparam int ABUS_PC           = 1;
   localparam int WE                = 2;
   localparam int IR_RBUS           = 3;
   localparam int INC_PC            = 4;
   localparam int R0_RBUS           = 5;
   localparam int MR_R0             = 6;
   localparam int ABUS_MR           = 7;
   localparam int ACC_RBUS          = 8;
   localparam int WBUS_ACC          = 9;
   localparam int ADD_OP            = 10;
   localparam int SUB_OP            = 11;
   localparam int ACC_ALU           = 12;
   localparam int PC_R0             = 13;
   localparam int MAX_CONTROL_LINES = 14;

   // PSW bit positions; bits [11:0] are always zero
   localparam int PSW_W = 16;
   localparam int PSW_Z = 15;
   localparam int PSW_N = 14;
   localparam int PSW_C = 13;
   localparam int PSW_V = 12;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   // Places the four ALU flags into their PSW positions, all other bits zero
   function automatic logic [PSW_W-1:0] psw_pack(input alu_flags_t f);
      logic [PSW_W-1:0] p;
      p        = '0;
      p[PSW_Z] = f.z;
      p[PSW_N] = f.n;
      p[PSW_C] = f.c;
      p[PSW_V] = f.v;
      return p;
   endfunction

endpackage

// File: rtl/mma_datapath_if.sv
// Control-unit / memory interface of the MMA datapath. The datapath is the
// responding end (slave); the control unit plus memory form the master side.
interface mma_datapath_if #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 12
) ();
   import mma_datapath_pkg::*;

   logic [0:MAX_CONTROL_LINES-1] control;
   logic [WORD_W-1:0]            mem_rdata;
   logic [ADDR_W-1:0]            mem_addr;
   logic [WORD_W-1:0]            mem_wdata;
   logic                         mem_we;
   logic [3:0]                   opcode;
   logic [PSW_W-1:0]             psw;
   logic                         ctl_err;

   modport master (
      output control, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, opcode, psw, ctl_err
   );

   modport slave (
      input  control, mem_rdata,
      output mem_addr, mem_wdata, mem_we, opcode, psw, ctl_err
   );

endinterface

// File: rtl/mma_datapath_alu.sv
// mma_alu: combinational add/subtract for the MMA datapath. Subtraction is
// a + ~b + 1, so the carry out is the no-borrow bit.
module mma_alu
   import mma_datapath_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  alu_op_e           op,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] result,
   output alu_flags_t        flags
);

   logic [WORD_W-1:0] b_eff;
   logic [WORD_W:0]   sum;

   // Single adder shared by both operations; flags derived from its result
   always_comb begin
      b_eff   = (op == ALU_SUB) ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, (op == ALU_SUB)};
      result  = sum[WORD_W-1:0];
      flags.z = (sum[WORD_W-1:0] == '0);
      flags.n = sum[WORD_W-1];
      flags.c = sum[WORD_W];
      // overflow: operands of equal sign produced a result of the other sign
      flags.v = (a[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
   end

endmodule

// File: rtl/mma_datapath.sv
// mma_datapath: register-transfer datapath of the MMA processor. Applies the
// control word each cycle to PC, IR, R0, MR, ACC, T and PSW and steers the
// memory buses. Optional feature macro: MMA_PSW_LOAD_FLAGS_EN (ACC loads
// also refresh PSW Z/N).
module mma_datapath
   import mma_datapath_pkg::*;
#(
   parameter int                WORD_W     = 16,
   parameter int                ADDR_W     = 12,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic          clk,
   input  logic          reset,
   mma_datapath_if.slave bus
);

   logic [0:MAX_CONTROL_LINES-1] ctl;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] ir_q, ir_d;
   logic [WORD_W-1:0] r0_q, r0_d;
   logic [ADDR_W-1:0] mr_q, mr_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [WORD_W-1:0] t_q, t_d;
   logic [PSW_W-1:0]  psw_q, psw_d;
   logic              ctl_err_q, ctl_err_d;

   alu_op_e           alu_op;
   logic [WORD_W-1:0] alu_result;
   alu_flags_t        alu_flags;

   assign ctl    = bus.control;
   assign alu_op = ctl[SUB_OP] ? ALU_SUB : ALU_ADD;

   mma_alu #(
      .WORD_W (WORD_W)
   ) u_alu (
      .op     (alu_op),
      .a      (acc_q),
      .b      (r0_q),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // Next-state for every register; an all-zero control word holds everything
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      r0_d      = r0_q;
      mr_d      = mr_q;
      acc_d     = acc_q;
      t_d       = t_q;
      psw_d     = psw_q;
      ctl_err_d = ctl_err_q;

      if (ctl[INIT_PC]) begin
         pc_d = START_ADDR;
      end else if (ctl[PC_R0]) begin
         pc_d = r0_q[ADDR_W-1:0];
      end else if (ctl[INC_PC]) begin
         pc_d = pc_q + ADDR_W'(1);
      end

      if (ctl[IR_RBUS]) ir_d = bus.mem_rdata;
      if (ctl[R0_RBUS]) r0_d = bus.mem_rdata;
      if (ctl[MR_R0])   mr_d = r0_q[ADDR_W-1:0];

      // ACC_ALU takes the T computed earlier, so it lags the ALU op by a cycle
      if (ctl[ACC_ALU]) begin
         acc_d = t_q;
         if (ctl[ACC_RBUS]) ctl_err_d = 1'b1;
      end else if (ctl[ACC_RBUS]) begin
         acc_d = bus.mem_rdata;
      end

`ifdef MMA_PSW_LOAD_FLAGS_EN
      // ACC loads refresh Z/N; an ALU op in the same cycle overrides below
      if (ctl[ACC_ALU] || ctl[ACC_RBUS]) begin
         psw_d[PSW_Z] = (acc_d == '0);
         psw_d[PSW_N] = acc_d[WORD_W-1];
      end
`endif

      if (ctl[ADD_OP] && ctl[SUB_OP]) begin
         ctl_err_d = 1'b1;
      end else if (ctl[ADD_OP] || ctl[SUB_OP]) begin
         t_d   = alu_result;
         psw_d = psw_pack(alu_flags);
      end

      // a write without the ACC on WBUS still goes out (as zero) but is flagged
      if (ctl[WE] && !ctl[WBUS_ACC]) ctl_err_d = 1'b1;
   end

   // Register bank; asynchronous reset clears all state, including PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= '0;
         ir_q      <= '0;
         r0_q      <= '0;
         mr_q      <= '0;
         acc_q     <= '0;
         t_q       <= '0;
         psw_q     <= '0;
         ctl_err_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         r0_q      <= r0_d;
         mr_q      <= mr_d;
         acc_q     <= acc_d;
         t_q       <= t_d;
         psw_q     <= psw_d;
         ctl_err_q <= ctl_err_d;
      end
   end

   // PC drives ABUS unless ABUS_MR selects MR; ABUS_PC is the default route
   assign bus.mem_addr  = ctl[ABUS_MR] ? mr_q : pc_q;
   assign bus.mem_wdata = ctl[WBUS_ACC] ? acc_q : '0;
   assign bus.mem_we    = ctl[WE];
   assign bus.opcode    = ir_q[WORD_W-1 -: 4];
   assign bus.psw       = psw_q;
   assign bus.ctl_err   = ctl_err_q;

endmodule

// File: tb/tb_mma_datapath.sv
// Testbench for mma_datapath: directed vector table, hand-written corner
// sequences (async reset, old-T load, error flags) and randomized control
// words checked against an arithmetic reference model.
module tb_mma_datapath;
   import mma_datapath_pkg::*;

   typedef logic [0:MAX_CONTROL_LINES-1] ctl_t;

   typedef struct {
      ctl_t        ctl;
      logic [15:0] rdata;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic        we;
      logic [3:0]  op;
      logic [15:0] psw;
      logic        err;
   } vec_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   // reference model state (plain integers)
   int m_pc, m_ir, m_r0, m_mr, m_acc, m_t, m_psw, m_err;

   mma_datapath_if #(.WORD_W(16), .ADDR_W(12)) bus ();

   mma_datapath #(
      .WORD_W     (16),
      .ADDR_W     (12),
      .START_ADDR (12'h000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic ctl_t cw(input int b0 = -1, input int b1 = -1, input int b2 = -1);
      ctl_t c;
      c = '0;
      if (b0 >= 0) c[b0] = 1'b1;
      if (b1 >= 0) c[b1] = 1'b1;
      if (b2 >= 0) c[b2] = 1'b1;
      return c;
   endfunction

   function automatic vec_t mk(input ctl_t c, input logic [15:0] rd, input logic [11:0] a,
                               input logic [15:0] w, input logic we, input logic [3:0] op,
                               input logic [15:0] ps, input logic e);
      vec_t v;
      v.ctl = c; v.rdata = rd; v.addr = a; v.wdata = w;
      v.we = we; v.op = op; v.psw = ps; v.err = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // apply a control word and read data at the falling edge, settle 1 time unit
   task automatic drive(input ctl_t c, input logic [15:0] rd);
      @(negedge clk);
      reset         = 1'b0;
      bus.control   = c;
      bus.mem_rdata = rd;
      #1;
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_r0 = 0; m_mr = 0;
      m_acc = 0; m_t = 0; m_psw = 0; m_err = 0;
   endtask

   function automatic int to_signed16(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   // outputs the model predicts for the current cycle
   task automatic model_check(input string tag, input ctl_t c);
      chk({tag, ".addr"},  32'(bus.mem_addr),  32'(c[ABUS_MR] ? m_mr : m_pc));
      chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(c[WBUS_ACC] ? m_acc : 0));
      chk({tag, ".we"},    32'(bus.mem_we),    32'(c[WE]));
      chk({tag, ".op"},    32'(bus.opcode),    32'(m_ir / 4096));
      chk({tag, ".psw"},   32'(bus.psw),       32'(m_psw));
      chk({tag, ".err"},   32'(bus.ctl_err),   32'(m_err));
   endtask

   // state change produced by one rising edge with control word c
   task automatic model_step(input ctl_t c, input int rd);
      int pc_n, ir_n, r0_n, mr_n, acc_n, t_n, psw_n, err_n;
      int s, sv, z, n, cy, v;
      pc_n = m_pc; ir_n = m_ir; r0_n = m_r0; mr_n = m_mr;
      acc_n = m_acc; t_n = m_t; psw_n = m_psw; err_n = m_err;
      if (c[INIT_PC])     pc_n = 0;
      else if (c[PC_R0])  pc_n = m_r0 % 4096;
      else if (c[INC_PC]) pc_n = (m_pc + 1) % 4096;
      if (c[IR_RBUS]) ir_n = rd;
      if (c[R0_RBUS]) r0_n = rd;
      if (c[MR_R0])   mr_n = m_r0 % 4096;
      if (c[ACC_ALU])       acc_n = m_t;
      else if (c[ACC_RBUS]) acc_n = rd;
      if (c[ACC_ALU] && c[ACC_RBUS]) err_n = 1;
      if (c[ADD_OP] && c[SUB_OP]) begin
         err_n = 1;
      end else if (c[ADD_OP] || c[SUB_OP]) begin
         if (c[ADD_OP]) begin
            s  = m_acc + m_r0;
            cy = (s >= 65536) ? 1 : 0;
            sv = to_signed16(m_acc) + to_signed16(m_r0);
         end else begin
            s  = m_acc - m_r0;
            cy = (m_acc >= m_r0) ? 1 : 0;
            sv = to_signed16(m_acc) - to_signed16(m_r0);
         end
         t_n   = (s + 65536) % 65536;
         z     = (t_n == 0) ? 1 : 0;
         n     = (t_n >= 32768) ? 1 : 0;
         v     = (sv > 32767 || sv < -32768) ? 1 : 0;
         psw_n = z * 32768 + n * 16384 + cy * 8192 + v * 4096;
      end
      if (c[WE] && !c[WBUS_ACC]) err_n = 1;
      m_pc = pc_n; m_ir = ir_n; m_r0 = r0_n; m_mr = mr_n;
      m_acc = acc_n; m_t = t_n; m_psw = psw_n; m_err = err_n;
   endtask

   initial begin
      vec_t tbl[$];
      ctl_t c;
      logic [15:0] rd;
      bit   did_rst;

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.control   = '0;
      bus.mem_rdata = '0;

      //               ctl                              rdata     addr     wdata    we    op    psw      err
      tbl.push_back(mk(cw(INIT_PC),                     16'h0000, 12'h000, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(IR_RBUS, INC_PC),             16'h2005, 12'h000, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(),                            16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(ACC_RBUS),                    16'h7FFF, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(R0_RBUS),                     16'h0001, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(ADD_OP),                      16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h0000, 1'b0));
      tbl.push_back(mk(cw(ACC_ALU, WBUS_ACC),           16'h0000, 12'h001, 16'h7FFF, 1'b0, 4'h2, 16'h5000, 1'b0));
      tbl.push_back(mk(cw(WBUS_ACC),                    16'h0000, 12'h001, 16'h8000, 1'b0, 4'h2, 16'h5000, 1'b0));
      tbl.push_back(mk(cw(ACC_RBUS),                    16'h0005, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h5000, 1'b0));
      tbl.push_back(mk(cw(R0_RBUS),                     16'h0005, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h5000, 1'b0));
      tbl.push_back(mk(cw(SUB_OP),                      16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'h5000, 1'b0));
      tbl.push_back(mk(cw(ACC_ALU),                     16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b0));
      tbl.push_back(mk(cw(WBUS_ACC),                    16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b0));
      tbl.push_back(mk(cw(ADD_OP, SUB_OP),              16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b0));
      tbl.push_back(mk(cw(),                            16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(R0_RBUS),                     16'h0010, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(MR_R0),                       16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(ACC_RBUS),                    16'h1234, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(ABUS_MR, WBUS_ACC, WE),       16'h0000, 12'h010, 16'h1234, 1'b1, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(R0_RBUS),                     16'h0FFF, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(PC_R0),                       16'h0000, 12'h001, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(INC_PC),                      16'h0000, 12'hFFF, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(),                            16'h0000, 12'h000, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(R0_RBUS),                     16'h0ABC, 12'h000, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(PC_R0, INC_PC),               16'h0000, 12'h000, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));
      tbl.push_back(mk(cw(),                            16'h0000, 12'hABC, 16'h0000, 1'b0, 4'h2, 16'hA000, 1'b1));

      repeat (2) @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ctl, tbl[i].rdata);
         chk($sformatf("tbl%0d.addr", i),  32'(bus.mem_addr),  32'(tbl[i].addr));
         chk($sformatf("tbl%0d.wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].wdata));
         chk($sformatf("tbl%0d.we", i),    32'(bus.mem_we),    32'(tbl[i].we));
         chk($sformatf("tbl%0d.op", i),    32'(bus.opcode),    32'(tbl[i].op));
         chk($sformatf("tbl%0d.psw", i),   32'(bus.psw),       32'(tbl[i].psw));
         chk($sformatf("tbl%0d.err", i),   32'(bus.ctl_err),   32'(tbl[i].err));
      end

      // asynchronous reset between edges clears everything at once
      drive(cw(INC_PC, WBUS_ACC, ABUS_MR), 16'h0000);
      chk("pre_rst.addr_mr", 32'(bus.mem_addr), 32'h010);
      #1 reset = 1'b1;
      #1;
      chk("async_rst.addr",  32'(bus.mem_addr),  32'h000);
      chk("async_rst.wdata", 32'(bus.mem_wdata), 32'h0000);
      chk("async_rst.psw",   32'(bus.psw),       32'h0000);
      chk("async_rst.op",    32'(bus.opcode),    32'h0);
      chk("async_rst.err",   32'(bus.ctl_err),   32'h0);
      @(negedge clk);
      chk("held_rst.addr",   32'(bus.mem_addr),  32'h000);
      drive(cw(INC_PC), 16'h0000);
      chk("rel_rst.pc",      32'(bus.mem_addr),  32'h000);
      drive(cw(), 16'h0000);
      chk("first_edge.pc",   32'(bus.mem_addr),  32'h001);

      // ACC_ALU alongside ADD_OP loads the previous T
      drive(cw(ACC_RBUS), 16'h0003);
      drive(cw(R0_RBUS), 16'h0004);
      drive(cw(ADD_OP), 16'h0000);
      drive(cw(R0_RBUS), 16'h0010);
      drive(cw(ADD_OP, ACC_ALU), 16'h0000);
      drive(cw(ACC_ALU, WBUS_ACC), 16'h0000);
      chk("oldT.acc",        32'(bus.mem_wdata), 32'h0007);
      drive(cw(WBUS_ACC), 16'h0000);
      chk("newT.acc",        32'(bus.mem_wdata), 32'h0013);
      chk("newT.err",        32'(bus.ctl_err),   32'h0);

      // WE without WBUS_ACC writes zero and flags an error
      drive(cw(WE), 16'h0000);
      chk("we_only.we",      32'(bus.mem_we),    32'h1);
      chk("we_only.wdata",   32'(bus.mem_wdata), 32'h0000);
      chk("we_only.err_pre", 32'(bus.ctl_err),   32'h0);
      drive(cw(), 16'h0000);
      chk("we_only.err",     32'(bus.ctl_err),   32'h1);

      // 0x8000 - 1: signed overflow with no borrow
      drive(cw(ACC_RBUS), 16'h8000);
      drive(cw(R0_RBUS), 16'h0001);
      drive(cw(SUB_OP), 16'h0000);
      drive(cw(), 16'h0000);
      chk("sub_ovf.psw",     32'(bus.psw),       32'h3000);

      // both ACC sources at once: ACC_ALU wins, error flagged
      @(negedge clk);
      reset = 1'b1;
      #1;
      drive(cw(ACC_RBUS, ACC_ALU), 16'h5555);
      chk("acc_both.err_pre", 32'(bus.ctl_err),  32'h0);
      drive(cw(WBUS_ACC), 16'h0000);
      chk("acc_both.acc",    32'(bus.mem_wdata), 32'h0000);
      chk("acc_both.err",    32'(bus.ctl_err),   32'h1);

      // randomized control words against the reference model
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 600; k++) begin
         c = '0;
         for (int b = 0; b < MAX_CONTROL_LINES; b++)
            c[b] = ($urandom_range(0, 3) == 0);
         rd = 16'($urandom);
         if ((k % 7) == 0) rd = 16'h8000 | 16'($urandom_range(0, 3));
         drive(c, rd);
         model_check($sformatf("rnd%0d", k), c);
         did_rst = ($urandom_range(0, 59) == 0);
         if (did_rst) begin
            reset = 1'b1;
            #1;
            model_reset();
            model_check($sformatf("rnd%0d_rst", k), c);
         end else begin
            model_step(c, int'(rd));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mma_datapath.md
# mma_datapath

Register-transfer datapath for the MMA processor. Every cycle it consumes the control word driven by the MMA control unit and performs the selected register loads, PC updates, ALU operations and memory-bus steering. It returns `opcode` and `psw` to the control unit, so it is the responding end of the control-line interface. It sits between the control unit and the unified instruction/data memory.

## Interface
- `WORD_W`, 16: data word width (IR, R0, ACC, ALU result, PSW)
- `ADDR_W`, 12: address width (PC, MR, memory address)
- `START_ADDR`, 0: value loaded into PC by `INIT_PC`

- `clk`  in  1  clock, all register updates on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `control`  in  [0:MAX_CONTROL_LINES-1]  control word from control unit; bit indices are the shared control-signal constants
- `mem_rdata`  in  WORD_W  read bus (RBUS) from memory, combinational read
- `mem_addr`  out  ADDR_W  address bus (ABUS)
- `mem_wdata`  out  WORD_W  write bus (WBUS)
- `mem_we`  out  1  memory write enable
- `opcode`  out  4  IR[15:12]
- `psw`  out  16  processor status word
- `ctl_err`  out  1  sticky flag for an illegal control combination

## Operation
- Registers: PC, IR, R0, MR, ACC, T (ALU result), PSW, ctl_err. All clear to 0 on reset. PC is the exception and resets to 0; it only becomes START_ADDR on `INIT_PC`.
- PC update priority: `INIT_PC` → START_ADDR; else `PC_R0` → R0[ADDR_W-1:0]; else `INC_PC` → PC+1, wrapping modulo 2^ADDR_W; else hold.
- `IR_RBUS`: IR ← mem_rdata.
- `R0_RBUS`: R0 ← mem_rdata.
- `MR_R0`: MR ← R0[ADDR_W-1:0].
- `ACC_RBUS`: ACC ← mem_rdata. `ACC_ALU`: ACC ← T. If both are set, `ACC_ALU` wins and ctl_err is set.
- `ADD_OP`: T ← ACC+R0. `SUB_OP`: T ← ACC−R0 (two's complement). Both update PSW.
- `ADD_OP` and `SUB_OP` together: T and PSW hold, ctl_err ← 1.
- PSW bits:
  - [15] Z = result zero
  - [14] N = result MSB
  - [13] C = carry out; for subtract this is the no-borrow bit
  - [12] V = signed overflow
  - [11:0] = 0
- The control unit's JNE jumps on psw[15]==0.
- mem_addr = MR when `ABUS_MR`, else PC.
- mem_wdata = ACC when `WBUS_ACC`, else 0.
- mem_we = `WE`. Asserting `WE` without `WBUS_ACC` sets ctl_err; the write of 0 still goes out.
- opcode = IR[15:12], continuously.
- ctl_err clears only on reset.

## Timing
- Control is combinational from the control-unit state. The datapath samples it at the rising edge that ends the state's cycle, so each load is visible in the next state's cycle. Latency is 1 cycle.
- Reads complete in one cycle: mem_addr and mem_rdata settle within the cycle in which the load bit is set.
- mem_addr, mem_wdata and mem_we are combinational from control and registers. Memory writes at the rising edge.
- The ALU takes 2 cycles: `ADD_OP` or `SUB_OP` in cycle n, then `ACC_ALU` in cycle n+1 or later. PSW is valid from cycle n+1.
- `ACC_ALU` in the same cycle as `ADD_OP` loads the old T.
- An all-zero control word holds every register.
- An asynchronous reset mid-instruction clears all registers immediately, whatever the control word is. The first edge after reset release applies the control word as normal.

## Configuration
- `MMA_PSW_LOAD_FLAGS_EN` defined: `ACC_RBUS` and `ACC_ALU` also update PSW Z and N from the new ACC value; C and V hold.
- `MMA_PSW_LOAD_FLAGS_EN` undefined: only `ADD_OP` and `SUB_OP` modify PSW.

## Structure
- Shared header (with the control-unit state constants):
  - control-line index constants (`INIT_PC`, `ABUS_PC`, `WE`, `IR_RBUS`, `INC_PC`, `R0_RBUS`, `MR_R0`, `ABUS_MR`, `ACC_RBUS`, `WBUS_ACC`, `ADD_OP`, `SUB_OP`, `ACC_ALU`, `PC_R0`)
  - `MAX_CONTROL_LINES`
  - PSW bit-position constants
- Sub-module `mma_alu`: combinational add/subtract producing the WORD_W result plus Z, N, C and V. The datapath instantiates it once.

## Test plan
- Reset, then `INIT_PC` for one cycle → PC=0x000, mem_addr=0x000, psw=0x0000, ctl_err=0.
- mem_rdata=0x2005 with `IR_RBUS`|`INC_PC` → next cycle IR=0x2005, opcode=4'h2, PC=0x001.
- ACC=0x7FFF, R0=0x0001, `ADD_OP` then `ACC_ALU` → ACC=0x8000, psw[15:12]=4'b0101.
- ACC=0x0005, R0=0x0005, `SUB_OP` then `ACC_ALU` → ACC=0x0000, psw[15:12]=4'b1010. Then `ADD_OP`|`SUB_OP` together → PSW unchanged, ctl_err=1.
- MR=0x010, ACC=0x1234, `ABUS_MR`|`WBUS_ACC`|`WE` → mem_addr=0x010, mem_wdata=0x1234, mem_we=1 in the same cycle.
- PC=0xFFF with `INC_PC` → PC=0x000. Then R0=0x0ABC with `PC_R0`|`INC_PC` → PC=0xABC. Assert reset mid-sequence → all registers 0 immediately.
